hbuf_pg_reader: RTL and testbench

- Downstream consumer of the mDOM hit buffer.
- When the hit buffer reports a stored DDR3 page, the block requests a read of that page into the page-transfer DPRAM. It then checks the header sync words and the CRC16, and streams the 2040 payload words out on a 16-bit valid/ready interface.
- After each page it frees the page through the hit-buffer controller's pg_clr request/ack interface with a count of 1.
- Sits between the hit-buffer controller/DDR3 arbiter and the readout packetizer.

---
 rtl/hbuf_pg_reader.sv | 180 ++++++++++++++++++
 tb/tb_hbuf_pg_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbuf_pg_reader.sv
// Hit-buffer page reader: pulls a stored DDR3 page into the transfer DPRAM,
// checks header/footer/CRC16, streams the 2040 payload words and frees the page.
module hbuf_pg_reader #(
  parameter int unsigned DPRAM_RD_LATENCY = 2,
  parameter int unsigned PG_ADDR_SHIFT    = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        hbuf_empty,
  input  logic [15:0] hbuf_rd_pg_num,
  output logic        pg_req,
  output logic        pg_optype,
  output logic [27:0] pg_addr,
  input  logic        pg_ack,
  output logic [8:0]  pg_dpram_rd_addr,
  input  logic [63:0] pg_dpram_dout,
  output logic [15:0] pg_clr_cnt,
  output logic        pg_clr_req,
  input  logic        pg_clr_ack,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        hdr_err,
  output logic        crc_err,
  output logic [15:0] crc_err_cnt,
  output logic [31:0] pgs_read
);

  localparam int unsigned LAT_W    = $clog2(DPRAM_RD_LATENCY + 2);
  localparam logic [63:0] HDR_WORD = 64'h5555_AAAA_5555_A000;
  localparam logic [47:0] FTR_WORD = 48'hAAAA_5555_AAAA;

  typedef enum logic [3:0] {
    S_IDLE, S_REQ, S_ACK_LOW, S_FETCH, S_HDR_CHK, S_SER, S_FTR_CHK, S_CLR_REQ, S_CLR_LOW
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_ack_meta, r_ack_sync;
  logic               r_pg_req, r_pg_clr_req, r_out_valid, r_hdr_err, r_crc_err;
  logic [27:0]        r_pg_addr;
  logic [8:0]         r_rd_addr;
  logic [63:0]        r_word;
  logic [15:0]        r_out_data, r_crc, r_crc_err_cnt;
  logic [31:0]        r_pgs_read;
  logic [1:0]         r_idx;
  logic [LAT_W-1:0]   r_lat;
  logic               w_fetch_done, w_hs;

  // CRC16, poly 0x8005, MSB first, one 16-bit word per call
  function automatic logic [15:0] crc16_word(input logic [15:0] crc, input logic [15:0] w);
    logic [15:0] c;
    c = crc ^ w;
    for (int i = 0; i < 16; i++) c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
    return c;
  endfunction

  assign w_fetch_done = (r_state == S_FETCH) && (r_lat == LAT_W'(DPRAM_RD_LATENCY));
  assign w_hs         = r_out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack_meta <= 1'b0;
      r_ack_sync <= 1'b0;
    end else begin
      r_ack_meta <= pg_ack;
      r_ack_sync <= r_ack_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (!hbuf_empty) w_state_nxt = S_REQ;
      S_REQ:     if (r_ack_sync) w_state_nxt = S_ACK_LOW;
      S_ACK_LOW: if (!r_ack_sync) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_fetch_done) begin
          if (r_rd_addr == 9'd0)        w_state_nxt = S_HDR_CHK;
          else if (r_rd_addr == 9'd511) w_state_nxt = S_FTR_CHK;
          else                          w_state_nxt = S_SER;
        end
      end
      S_HDR_CHK: w_state_nxt = (r_word == HDR_WORD) ? S_FETCH : S_CLR_REQ;
      S_SER:     if (w_hs && (r_idx == 2'd3)) w_state_nxt = S_FETCH;
      S_FTR_CHK: w_state_nxt = S_CLR_REQ;
      S_CLR_REQ: if (pg_clr_ack) w_state_nxt = S_CLR_LOW;
      S_CLR_LOW: if (!pg_clr_ack) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
    if (!en) w_state_nxt = S_IDLE;
  end

  // Datapath; disable drops the page in flight but keeps the status counters
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      r_pg_req     <= 1'b0;
      r_pg_clr_req <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= 16'd0;
      r_crc_err    <= 1'b0;
      r_pg_addr    <= 28'd0;
      r_rd_addr    <= 9'd0;
      r_word       <= 64'd0;
      r_crc        <= 16'hFFFF;
      r_idx        <= 2'd0;
      r_lat        <= '0;
      if (!rst_n) begin
        r_hdr_err     <= 1'b0;
        r_crc_err_cnt <= 16'd0;
        r_pgs_read    <= 32'd0;
      end
    end else begin
      r_crc_err    <= 1'b0;
      r_pg_req     <= (w_state_nxt == S_REQ);
      r_pg_clr_req <= (w_state_nxt == S_CLR_REQ);
      case (r_state)
        S_IDLE: if (w_state_nxt == S_REQ) r_pg_addr <= 28'(28'(hbuf_rd_pg_num) << PG_ADDR_SHIFT);
        S_ACK_LOW: if (w_state_nxt == S_FETCH) begin
          r_rd_addr <= 9'd0;
          r_crc     <= 16'hFFFF;
        end
        S_FETCH: begin
          r_lat <= r_lat + LAT_W'(1);
          if (w_fetch_done) begin
            r_lat  <= '0;
            r_word <= pg_dpram_dout;
            if (w_state_nxt == S_SER) begin
              r_out_valid <= 1'b1;
              r_out_data  <= pg_dpram_dout[15:0];
              r_idx       <= 2'd0;
            end
          end
        end
        S_HDR_CHK: begin
          if (r_word == HDR_WORD) r_rd_addr <= 9'd1;
          else                    r_hdr_err <= 1'b1;
        end
        S_SER: if (w_hs) begin
          r_crc <= crc16_word(r_crc, r_out_data);
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_out_valid <= 1'b0;
            r_rd_addr   <= r_rd_addr + 9'd1;
          end else begin
            r_out_data <= 16'(r_word >> {r_idx + 2'd1, 4'd0});
          end
        end
        S_FTR_CHK: begin
          if (r_word[47:0] != FTR_WORD) r_hdr_err <= 1'b1;
          if (r_word[63:48] != r_crc) begin
            r_crc_err <= 1'b1;
            if (r_crc_err_cnt != 16'hFFFF) r_crc_err_cnt <= r_crc_err_cnt + 16'd1;
          end
        end
        S_CLR_LOW: if (w_state_nxt == S_IDLE) r_pgs_read <= r_pgs_read + 32'd1;
        default: ;
      endcase
    end
  end

  assign pg_req           = r_pg_req;
  assign pg_optype        = 1'b0;
  assign pg_addr          = r_pg_addr;
  assign pg_dpram_rd_addr = r_rd_addr;
  assign pg_clr_cnt       = 16'd1;
  assign pg_clr_req       = r_pg_clr_req;
  assign out_data         = r_out_data;
  assign out_valid        = r_out_valid;
  assign hdr_err          = r_hdr_err;
  assign crc_err          = r_crc_err;
  assign crc_err_cnt      = r_crc_err_cnt;
  assign pgs_read         = r_pgs_read;

endmodule

// File: tb/tb_hbuf_pg_reader.sv
// Bench for hbuf_pg_reader: hit-buffer queue, DDR3/DPRAM and clear responders,
// with the expected payload stream built from each page image.
module tb_hbuf_pg_reader;
  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n, en, hbuf_empty, pg_req, pg_optype, pg_ack, pg_clr_req, pg_clr_ack;
  logic [15:0] hbuf_rd_pg_num, pg_clr_cnt, out_data, crc_err_cnt;
  logic [27:0] pg_addr;
  logic [8:0]  pg_dpram_rd_addr;
  logic [63:0] pg_dpram_dout;
  logic        out_valid, out_ready, hdr_err, crc_err;
  logic [31:0] pgs_read;

  always #5 clk = ~clk;

  hbuf_pg_reader #(.DPRAM_RD_LATENCY(LAT), .PG_ADDR_SHIFT(12)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .hbuf_empty(hbuf_empty), .hbuf_rd_pg_num(hbuf_rd_pg_num),
    .pg_req(pg_req), .pg_optype(pg_optype), .pg_addr(pg_addr), .pg_ack(pg_ack),
    .pg_dpram_rd_addr(pg_dpram_rd_addr), .pg_dpram_dout(pg_dpram_dout),
    .pg_clr_cnt(pg_clr_cnt), .pg_clr_req(pg_clr_req), .pg_clr_ack(pg_clr_ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .hdr_err(hdr_err), .crc_err(crc_err), .crc_err_cnt(crc_err_cnt), .pgs_read(pgs_read)
  );

  int total = 0, bad = 0;
  logic [15:0] hb_q[$];
  int          kind_q[$];
  logic [15:0] exp_q[$];
  int          exp_pages = 0, exp_crc_errs = 0, req_cnt = 0, clr_cnt = 0;
  int          hs_cnt = 0, first_mark = 0, crc_pulses = 0;
  logic        exp_hdr_err = 1'b0, rdy_rand = 1'b0;
  int          ack_dly = 3, clr_dly = 2;
  logic [15:0] first_w, last_w;
  logic [27:0] last_addr;

  // Page DPRAM with LAT-cycle registered read
  logic [63:0] mem  [512];
  logic [63:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= mem[pg_dpram_rd_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign pg_dpram_dout = pipe[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Bit-serial CRC16 (poly 0x8005, MSB first, no reflection)
  function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [15:0] d, input int nbits);
    logic [15:0] c;
    logic        fb;
    c = c_in;
    for (int i = nbits - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h8005;
    end
    return c;
  endfunction

  task automatic hb_update();
    hbuf_empty     = (hb_q.size() == 0);
    hbuf_rd_pg_num = (hb_q.size() > 0) ? hb_q[0] : 16'h0;
  endtask

  task automatic push_page(input logic [15:0] pg, input int kind);
    hb_q.push_back(pg);
    kind_q.push_back(kind);
    hb_update();
  endtask

  // kind 0: counting payload, 1: random payload with zero fillers,
  // 2: counting payload with corrupted CRC, 3: bad header
  task automatic load_image(input int kind);
    logic [15:0] w, crc;
    crc    = 16'hFFFF;
    mem[0] = 64'h5555_AAAA_5555_A000;
    if (kind == 3) mem[0][15:0] = 16'hA001;
    for (int a = 1; a < 511; a++) begin
      for (int k = 0; k < 4; k++) begin
        if (kind == 1) begin
          w = 16'($urandom);
          if (w[2:0] == 3'd0) w = 16'h0000;
        end else begin
          w = 16'((a - 1) * 4 + k);
        end
        mem[a][16*k +: 16] = w;
        crc = crc_model(crc, w, 16);
        if (kind != 3) exp_q.push_back(w);
      end
    end
    if (kind == 2) crc = crc ^ 16'h0001;
    mem[511] = {crc, 48'hAAAA_5555_AAAA};
  endtask

  // DDR3 arbiter responder
  initial begin
    int n;
    pg_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pg_req && !pg_ack) begin
        req_cnt++;
        last_addr = pg_addr;
        chk("pg_optype", 64'(pg_optype), 64'd0);
        if (hb_q.size() == 0) begin
          chk("req_with_empty_hbuf", 64'(hb_q.size()), 64'd1);
        end else begin
          chk("pg_addr", 64'(pg_addr), 64'({hb_q[0], 12'h000}));
          repeat (ack_dly) @(posedge clk);
          #1;
          load_image(kind_q[0]);
        end
        pg_ack = 1'b1;
        n = 0;
        while (pg_req && n < 200) begin @(posedge clk); #1; n++; end
        chk("pg_req_drop", 64'(pg_req), 64'd0);
        @(posedge clk); #1;
        pg_ack = 1'b0;
      end
    end
  end

  // Hit-buffer clear responder; model totals advance when a page is freed
  initial begin
    int n, kind;
    pg_clr_ack = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (pg_clr_req && !pg_clr_ack) begin
        repeat (clr_dly) @(posedge clk);
        #1;
        clr_cnt++;
        chk("words_left_at_clr", 64'(exp_q.size()), 64'd0);
        if (kind_q.size() > 0) begin
          kind = kind_q.pop_front();
          void'(hb_q.pop_front());
          hb_update();
          exp_pages++;
          if (kind == 2) exp_crc_errs++;
          if (kind == 3) exp_hdr_err = 1'b1;
        end
        pg_clr_ack = 1'b1;
        n = 0;
        while (pg_clr_req && n < 200) begin @(posedge clk); #1; n++; end
        chk("pg_clr_req_drop", 64'(pg_clr_req), 64'd0);
        @(posedge clk); #1;
        pg_clr_ack = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output compare on the falling edge
  initial begin
    logic        prev_v, prev_r, prev_en;
    logic [15:0] prev_d, ew;
    prev_v = 1'b0; prev_r = 1'b0; prev_en = 1'b0; prev_d = 16'h0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_v && !prev_r && prev_en) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'(out_data), 64'(prev_d));
        end
        if (out_valid && out_ready && en) begin
          if (exp_q.size() == 0) begin
            chk("extra_word", 64'(exp_q.size()), 64'd1);
          end else begin
            ew = exp_q.pop_front();
            chk("word", 64'(out_data), 64'(ew));
          end
          if (hs_cnt == first_mark) first_w = out_data;
          last_w = out_data;
          hs_cnt++;
        end
        if (crc_err) crc_pulses++;
        if (pg_clr_req) chk("pg_clr_cnt", 64'(pg_clr_cnt), 64'd1);
      end
      prev_v = out_valid; prev_r = out_ready; prev_d = out_data; prev_en = en;
    end
  end

  task automatic wait_pages(input int target);
    int n = 0;
    while (exp_pages < target && n < 40000) begin @(posedge clk); #1; n++; end
    chk("page_timeout", 64'(exp_pages >= target), 64'd1);
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag);
    chk({tag, "_pgs_read_model"}, 64'(pgs_read), 64'(exp_pages));
    chk({tag, "_crc_cnt_model"}, 64'(crc_err_cnt), 64'(exp_crc_errs));
    chk({tag, "_hdr_err_model"}, 64'(hdr_err), 64'(exp_hdr_err));
    chk({tag, "_crc_pulses"}, 64'(crc_pulses), 64'(exp_crc_errs));
  endtask

  initial begin
    int base_hs, base_req, n;
    logic [15:0] c;
    rst_n = 1'b0; en = 1'b0;
    hb_update();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pg_req", 64'(pg_req), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pg_clr_req", 64'(pg_clr_req), 64'd0);
    chk("rst_pg_addr", 64'(pg_addr), 64'd0);
    chk("rst_rd_addr", 64'(pg_dpram_rd_addr), 64'd0);
    chk("rst_status", 64'({hdr_err, crc_err, crc_err_cnt, pgs_read}), 64'd0);
    rst_n = 1'b1; en = 1'b1;

    // Pin the CRC model against the CRC-16/CMS check value
    c = 16'hFFFF;
    for (int i = 0; i < 9; i++) c = crc_model(c, 16'(8'h31 + 8'(i)), 8);
    chk("crc_model_check", 64'(c), 64'hAEE7);

    // One good page, out_ready held high
    base_hs = hs_cnt; base_req = req_cnt; first_mark = hs_cnt;
    push_page(16'd5, 0);
    wait_pages(1);
    chk("t1_words", 64'(hs_cnt - base_hs), 64'd2040);
    chk("t1_first", 64'(first_w), 64'd0);
    chk("t1_last", 64'(last_w), 64'd2039);
    chk("t1_addr", 64'(last_addr), 64'h0005000);
    chk("t1_reqs", 64'(req_cnt - base_req), 64'd1);
    chk("t1_clrs", 64'(clr_cnt), 64'd1);
    chk("t1_pgs_read", 64'(pgs_read), 64'd1);
    chk("t1_crc_cnt", 64'(crc_err_cnt), 64'd0);
    chk_status("t1");

    // Same page with random back-pressure
    rdy_rand = 1'b1;
    base_hs = hs_cnt; first_mark = hs_cnt;
    push_page(16'd9, 0);
    wait_pages(2);
    rdy_rand = 1'b0;
    chk("t2_words", 64'(hs_cnt - base_hs), 64'd2040);
    chk("t2_last", 64'(last_w), 64'd2039);
    chk("t2_pgs_read", 64'(pgs_read), 64'd2);
    chk_status("t2");

    // Corrupted footer CRC
    base_hs = hs_cnt;
    push_page(16'd3, 2);
    wait_pages(3);
    chk("t3_words", 64'(hs_cnt - base_hs), 64'd2040);
    chk("t3_crc_cnt", 64'(crc_err_cnt), 64'd1);
    chk("t3_hdr_err", 64'(hdr_err), 64'd0);
    chk_status("t3");

    // Bad header: no payload, page still freed
    base_hs = hs_cnt;
    push_page(16'd7, 3);
    wait_pages(4);
    chk("t4_words", 64'(hs_cnt - base_hs), 64'd0);
    chk("t4_hdr_err", 64'(hdr_err), 64'd1);
    chk("t4_pgs_read", 64'(pgs_read), 64'd4);
    chk_status("t4");

    // Three queued pages with slow acknowledges
    ack_dly = 20; clr_dly = 7;
    base_hs = hs_cnt; base_req = req_cnt;
    push_page(16'd10, 1); push_page(16'd11, 1); push_page(16'd12, 1);
    wait_pages(7);
    chk("t5_words", 64'(hs_cnt - base_hs), 64'd6120);
    chk("t5_reqs", 64'(req_cnt - base_req), 64'd3);
    chk("t5_pgs_read", 64'(pgs_read), 64'd7);
    chk_status("t5");
    ack_dly = 3; clr_dly = 2;

    // Disable mid-stream after 1000 words, then restart the same page
    base_hs = hs_cnt; base_req = req_cnt;
    push_page(16'd20, 1);
    n = 0;
    while ((hs_cnt - base_hs) < 1000 && n < 20000) begin @(posedge clk); #1; n++; end
    chk("t6_reach_1000", 64'(hs_cnt - base_hs), 64'd1000);
    en = 1'b0;
    @(posedge clk); #1;
    chk("t6_off_valid", 64'(out_valid), 64'd0);
    chk("t6_off_req", 64'(pg_req), 64'd0);
    chk("t6_off_clr", 64'(pg_clr_req), 64'd0);
    chk("t6_off_rd_addr", 64'(pg_dpram_rd_addr), 64'd0);
    chk("t6_off_held", 64'({hdr_err, crc_err_cnt, pgs_read}), 64'({1'b1, 16'd1, 32'd7}));
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1;
    base_hs = hs_cnt;
    en = 1'b1;
    wait_pages(8);
    chk("t6_words", 64'(hs_cnt - base_hs), 64'd2040);
    chk("t6_reqs", 64'(req_cnt - base_req), 64'd2);
    chk("t6_addr", 64'(last_addr), 64'h0014000);
    chk("t6_pgs_read", 64'(pgs_read), 64'd8);
    chk_status("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
